cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Memory-side responder for the per-CPU cache control interface. It accepts word requests from the data cache (read/write) and the instruction cache (read-only), arbitrates between them, drives a single-ported RAM, and returns the `dwait`/`iwait` handshake and load data. It sits between the caches' `ccif` request lines and the RAM model.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: number of consecutive dcache grants, with `iREN` pending, before icache is forced a grant; range 1-7.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `dwait`  out  1  0 for exactly one cycle when the dcache word completes.
- `dload`  out  32  dcache read data; valid only while `dwait`=0.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `iwait`  out  1  0 for exactly one cycle when the icache word completes.
- `iload`  out  32  icache read data; valid only while `iwait`=0.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data; valid while `ramack`=1.
- `ramack`  in  1  RAM access completes this cycle.

## Operation
- States: `IDLE`, `D_ACC`, `I_ACC`.
- `IDLE`: all `ram*` strobes 0, `dwait`=`iwait`=1. Grant on this cycle's requests:
  - d request (`dREN|dWEN`) and no `iREN` -> `D_ACC`.
  - `iREN` and no d request -> `I_ACC`.
  - Both pending -> `D_ACC`, unless `streak`==`STARVE_LIMIT`, then `I_ACC`.
  - Neither -> stay in `IDLE`.
- `streak` is a 3-bit register. It increments (saturating at 7) on a d grant made while `iREN`=1. It clears on an i grant, and on a d grant made with `iREN`=0.
- `D_ACC`:
  - `ramaddr`=`daddr` (combinational).
  - `dWEN`=1 -> `ramWEN`=1, `ramstore`=`dstore`, `ramREN`=0. Write wins if `dREN` and `dWEN` are both high.
  - Otherwise `ramREN`=1.
  - On `ramack`: `dwait`=0 and `dload`=`ramload` in the same cycle; next state `IDLE`.
- `I_ACC`: `ramREN`=1, `ramaddr`=`iaddr`. On `ramack`: `iwait`=0 and `iload`=`ramload`; next state `IDLE`.
- Withdrawal: if the granted requester drops all of its request lines while in `*_ACC`, strobes go 0 that cycle, no wait is released, and the next state is `IDLE`. A `ramack` arriving in that cycle is ignored.
- The non-granted port keeps wait=1 throughout.
- `dload`/`iload` are 0 whenever their wait is 1.
- `ramstore` is 0 unless writing.
- `ramaddr` is 0 in `IDLE`.

## Timing
- Reset (async, any state, including mid-access):
  - state=`IDLE`, `streak`=0.
  - `dwait`=`iwait`=1, `dload`=`iload`=0.
  - `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
- Minimum latency: request seen in cycle N (`IDLE`) -> RAM strobe in cycle N+1 -> wait low in cycle N+1 at the earliest (`ramack` in that cycle).
- Each word costs at least 2 cycles, because the block returns through `IDLE`.
- Requesters hold address, data and strobes stable until their wait goes 0. The block does not register `daddr`, `dstore` or `iaddr`.
- A requester that changes its address in the cycle after its wait=0 is sampled as a fresh request in `IDLE`.
- The RAM may hold `ramack`=0 for an unbounded number of cycles; the block waits indefinitely, with no timeout.
- All outputs derive from the registered state plus the current inputs. The only registered elements are state and `streak`.

## Test plan
- Reset mid-`D_ACC` with `ramREN`=1 -> same cycle: `ramREN`=0, `dwait`=1. After release with no requests -> stays in `IDLE`.
- dcache read `daddr`=0x100, RAM acks 3 cycles after the strobe with `ramload`=0xDEADBEEF -> `dwait`=0 for exactly one cycle with `dload`=0xDEADBEEF; `ramWEN` never asserted.
- dcache `dWEN`=`dREN`=1, `daddr`=0x3100, `dstore`=0x2A -> `ramWEN`=1, `ramREN`=0, `ramaddr`=0x3100, `ramstore`=0x2A.
- Simultaneous `dREN` and `iREN` on the first request after reset -> dcache served first; `iwait` stays 1 until the following grant.
- `iREN` held continuously and dcache re-requesting every cycle, `STARVE_LIMIT`=4 -> grant order D,D,D,D,I,D….
- dcache drops `dREN` while in `D_ACC`, with `ramack`=1 in that same cycle -> `dwait` stays 1, `ramREN`=0 that cycle, next state `IDLE`.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Memory-side responder: arbitrates dcache (r/w) and icache (r) word requests
// onto a single-ported RAM and returns the wait/load handshake to each cache.
module cache_mem_responder #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramack
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [2:0] streak, streak_nxt;
  logic       dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= 3'd0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    dwait      = 1'b1;
    iwait      = 1'b1;
    dload      = 32'h0;
    iload      = 32'h0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = 32'h0;
    ramstore   = 32'h0;
    case (state)
      IDLE: begin
        // dcache wins a tie until it has beaten a waiting icache LIMIT times
        if (dreq && !(iREN && streak == LIMIT)) begin
          state_nxt  = D_ACC;
          streak_nxt = !iREN ? 3'd0 : (streak == 3'd7) ? 3'd7 : streak + 3'd1;
        end else if (iREN) begin
          state_nxt  = I_ACC;
          streak_nxt = 3'd0;
        end
      end
      D_ACC: begin
        if (!dreq) begin
          state_nxt = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramack) begin
            dwait     = 1'b0;
            dload     = ramload;
            state_nxt = IDLE;
          end
        end
      end
      I_ACC: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramack) begin
            iwait     = 1'b0;
            iload     = ramload;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench: vector table plus scoreboard queues fed at drive time
// and drained whenever dwait/iwait drop; a small RAM model answers strobes.
module tb_cache_mem_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dREN, dWEN, iREN;
  logic [31:0] daddr, dstore, iaddr;
  logic        dwait, iwait;
  logic [31:0] dload, iload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic        ramack;
  logic        ack_m, ack_force;

  assign ramack = ack_m | ack_force;

  cache_mem_responder #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramack(ramack)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic        is_i;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    int          lat;
    logic [1:0]  exp_str;   // {ramWEN, ramREN}
    logic [31:0] exp_raddr;
    logic [31:0] exp_rstore;
    logic        chk;
    logic [31:0] exp_data;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  sb_t   dq[$];
  sb_t   iq[$];
  string order_s = "";
  int    lat = 0;
  int    cnt = 0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : f(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s required=%s", nm, act, exp);
    end
  endtask

  // RAM model: acks `lat` cycles after the strobe first appears
  always @(posedge CLK) begin
    #2;
    if (nRST && (ramREN || ramWEN)) begin
      ack_m   = (cnt >= lat);
      ramload = (ack_m && ramREN) ? rd(ramaddr) : 32'h0;
      if (ack_m && ramWEN) mem[ramaddr] = ramstore;
      cnt++;
    end else begin
      cnt     = 0;
      ack_m   = 1'b0;
      ramload = 32'h0;
    end
  end

  // Scoreboard / invariant monitor
  always @(negedge CLK) begin
    sb_t e;
    if (nRST) begin
      if (!dwait) begin
        order_s = {order_s, "D"};
        if (dq.size() == 0) chk("d_spurious_wait", {63'h0, dwait}, 64'h1);
        else begin
          e = dq.pop_front();
          if (e.chk) chk("dload", {32'h0, dload}, {32'h0, e.data});
        end
      end else chk("dload_zero_when_waiting", {32'h0, dload}, 64'h0);
      if (!iwait) begin
        order_s = {order_s, "I"};
        if (iq.size() == 0) chk("i_spurious_wait", {63'h0, iwait}, 64'h1);
        else begin
          e = iq.pop_front();
          if (e.chk) chk("iload", {32'h0, iload}, {32'h0, e.data});
        end
      end else chk("iload_zero_when_waiting", {32'h0, iload}, 64'h0);
      if (!ramWEN) chk("ramstore_zero_no_write", {32'h0, ramstore}, 64'h0);
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    sb_t  e;
    logic done;
    @(posedge CLK); #1;
    lat    = v.lat;
    e.chk  = v.chk;
    e.data = v.exp_data;
    if (v.is_i) begin
      iq.push_back(e);
      iREN = 1'b1; iaddr = v.addr;
    end else begin
      dq.push_back(e);
      dREN = v.ren; dWEN = v.wen; daddr = v.addr; dstore = v.store;
    end
    @(negedge CLK);
    chk($sformatf("v%0d_idle_strobes", idx), {62'h0, ramWEN, ramREN}, 64'h0);
    chk($sformatf("v%0d_idle_ramaddr", idx), {32'h0, ramaddr}, 64'h0);
    @(negedge CLK);
    chk($sformatf("v%0d_strobe", idx), {62'h0, ramWEN, ramREN}, {62'h0, v.exp_str});
    chk($sformatf("v%0d_ramaddr", idx), {32'h0, ramaddr}, {32'h0, v.exp_raddr});
    chk($sformatf("v%0d_ramstore", idx), {32'h0, ramstore}, {32'h0, v.exp_rstore});
    done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (v.is_i ? !iwait : !dwait) begin done = 1'b1; break; end
      @(negedge CLK);
    end
    chk($sformatf("v%0d_completed", idx), {63'h0, done}, 64'h1);
    @(posedge CLK); #1;
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    @(negedge CLK);
    chk($sformatf("v%0d_wait_one_cycle", idx), {62'h0, dwait, iwait}, 64'h3);
  endtask

  initial begin
    vec_t vecs[7];
    sb_t  e;
    logic ddone, idone;
    int   ncomp;

    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    sb_t  e;
    logic ddone, idone;
    int   ncomp;

    mem[32'h100] = 32'hDEADBEEF;
    //          is_i ren  wen  addr           store          lat str    raddr          rstore         chk  data
    vecs[0] = '{1'b0,1'b1,1'b0,32'h0000_0100, 32'h0,         3, 2'b01, 32'h0000_0100, 32'h0,         1'b1,32'hDEADBEEF};
    vecs[1] = '{1'b0,1'b1,1'b1,32'h0000_3100, 32'h0000_002A, 1, 2'b10, 32'h0000_3100, 32'h0000_002A, 1'b0,32'h0};
    vecs[2] = '{1'b0,1'b1,1'b0,32'h0000_3100, 32'h0,         0, 2'b01, 32'h0000_3100, 32'h0,         1'b1,32'h0000_002A};
    vecs[3] = '{1'b1,1'b0,1'b0,32'h0000_0200, 32'h0,         2, 2'b01, 32'h0000_0200, 32'h0,         1'b1,f(32'h200)};
    vecs[4] = '{1'b0,1'b0,1'b1,32'h0000_0044, 32'hCAFEF00D,  0, 2'b10, 32'h0000_0044, 32'hCAFEF00D,  1'b0,32'h0};
    vecs[5] = '{1'b1,1'b0,1'b0,32'h0000_0044, 32'h0,         1, 2'b01, 32'h0000_0044, 32'h0,         1'b1,32'hCAFEF00D};
    vecs[6] = '{1'b0,1'b1,1'b0,32'hFFFF_FFFC, 32'h0,         5, 2'b01, 32'hFFFF_FFFC, 32'h0,         1'b1,f(32'hFFFFFFFC)};

    nRST = 1'b0; dWEN = 1'b0; iREN = 1'b0; ack_force = 1'b0; ack_m = 1'b0; ramload = 32'h0;
    dREN = 1'b1; daddr = 32'h1234; dstore = 32'h5678; iaddr = 32'h0;
    #12;
    chk("reset_waits", {62'h0, dwait, iwait}, 64'h3);
    chk("reset_loads", {dload, iload}, 64'h0);
    chk("reset_strobes", {62'h0, ramWEN, ramREN}, 64'h0);
    chk("reset_ram_bus", {ramaddr, ramstore}, 64'h0);
    dREN = 1'b0; daddr = 32'h0; dstore = 32'h0;
    @(posedge CLK); #3 nRST = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset asserted mid-access
    @(posedge CLK); #1;
    lat = 100; dREN = 1'b1; daddr = 32'h500;
    @(negedge CLK);
    @(negedge CLK);
    chk("midrst_strobe_before", {63'h0, ramREN}, 64'h1);
    @(negedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk("midrst_ramREN", {63'h0, ramREN}, 64'h0);
    chk("midrst_dwait", {63'h0, dwait}, 64'h1);
    chk("midrst_ramaddr", {32'h0, ramaddr}, 64'h0);
    @(posedge CLK); #1;
    dREN = 1'b0;
    #2 nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("postrst_idle_%0d", c), {30'h0, ramWEN, ramREN, ramaddr}, 64'h0);
    end

    // Simultaneous first requests after reset: dcache first
    @(posedge CLK); #1;
    lat = 1; order_s = "";
    e.chk = 1'b1; e.data = f(32'h600); dq.push_back(e);
    e.chk = 1'b1; e.data = f(32'h700); iq.push_back(e);
    dREN = 1'b1; daddr = 32'h600; iREN = 1'b1; iaddr = 32'h700;
    ddone = 1'b0; idone = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (!ddone) chk("simul_iwait_held", {63'h0, iwait}, 64'h1);
      if (!dwait) ddone = 1'b1;
      if (!iwait) idone = 1'b1;
      if (ddone && idone) break;
      @(posedge CLK); #1;
      if (ddone) dREN = 1'b0;
      if (idone) iREN = 1'b0;
    end
    @(posedge CLK); #1;
    dREN = 1'b0; iREN = 1'b0;
    chk_str("simul_grant_order", order_s, "DI");

    // Starvation: both held, dcache re-requesting every cycle
    @(posedge CLK); #1;
    lat = 0; order_s = "";
    e.chk = 1'b1; e.data = f(32'h800);
    for (int k = 0; k < 5; k++) dq.push_back(e);
    e.data = f(32'h900); iq.push_back(e);
    dREN = 1'b1; daddr = 32'h800; iREN = 1'b1; iaddr = 32'h900;
    ncomp = 0; idone = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!dwait) ncomp++;
      if (!iwait) begin ncomp++; idone = 1'b1; end
      if (ncomp >= 6) break;
      @(posedge CLK); #1;
      if (idone) iREN = 1'b0;
    end
    @(posedge CLK); #1;
    dREN = 1'b0; iREN = 1'b0;
    chk_str("starve_grant_order", order_s, "DDDDID");

    // Withdrawal with a coincident ramack
    @(posedge CLK); #1;
    lat = 10; dREN = 1'b1; daddr = 32'hA00;
    @(negedge CLK);
    @(negedge CLK);
    chk("wd_strobe_before", {63'h0, ramREN}, 64'h1);
    @(posedge CLK); #1;
    dREN = 1'b0; ack_force = 1'b1;
    @(negedge CLK);
    chk("wd_dwait_held", {63'h0, dwait}, 64'h1);
    chk("wd_strobes_off", {62'h0, ramWEN, ramREN}, 64'h0);
    @(posedge CLK); #1;
    ack_force = 1'b0;
    @(negedge CLK);
    chk("wd_next_idle", {30'h0, ramWEN, ramREN, ramaddr}, 64'h0);

    run_vec(vecs[2], 7);

    chk("scoreboard_drained", {32'h0, 16'(dq.size()), 16'(iq.size())}, 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
